// File: rtl/delay_tap_encoder_if.sv
// Result hand-off bus of the delay-tap encoder: count, flags and a valid/ready pair.
// valid/ready: a transfer happens on a rising edge where valid && ready; while valid
// is high and ready is low the producer holds result/flags/valid unchanged.
interface delay_tap_encoder_if #(
    parameter int CNT_W = 7
);
    logic [CNT_W-1:0] result;
    logic             edge_found;
    logic             overflow;
    logic             valid;
    logic             ready;

    modport master (
        output result,
        output edge_found,
        output overflow,
        output valid,
        input  ready
    );

    modport slave (
        input  result,
        input  edge_found,
        input  overflow,
        input  valid,
        output ready
    );
endinterface

// File: rtl/delay_tap_encoder.sv
// Snapshots a delay-line thermometer code on trigger, removes single-tap bubbles with
// a 3-tap majority vote, and hands the leading-ones count off over valid/ready.
module delay_tap_encoder #(
    parameter int N_TAPS = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TAPS-1:0] taps,
    input  logic              arm,
    input  logic              trigger,
    output logic              busy,
    output logic [2:0]        state_dbg,
    delay_tap_encoder_if.master res_if
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        FILTER = 3'd2,
        ENCODE = 3'd3,
        OUTPUT = 3'd4
    } state_t;

    state_t            state_q;
    logic [N_TAPS-1:0] snapshot_q;
    logic [N_TAPS-1:0] corrected_q;
    logic [N_TAPS-1:0] corrected_d;
    logic [CNT_W-1:0]  result_q;
    logic [CNT_W-1:0]  count_d;
    logic              edge_found_q;
    logic              overflow_q;
    logic              valid_q;
    logic              busy_q;

    // Edge taps are padded by replicating themselves, so padded[i+1] is tap i.
    logic [N_TAPS+1:0] padded;
    assign padded = {snapshot_q[N_TAPS-1], snapshot_q, snapshot_q[0]};

    always_comb begin
        corrected_d = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            corrected_d[i] = (padded[i] & padded[i+1]) |
                             (padded[i+1] & padded[i+2]) |
                             (padded[i] & padded[i+2]);
        end
    end

    // Leading-ones count: the run stops at the first zero; later ones never count.
    always_comb begin
        logic run;
        count_d = '0;
        run     = 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
            run = run & corrected_q[i];
            if (run) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snapshot_q   <= '0;
            corrected_q  <= '0;
            result_q     <= '0;
            edge_found_q <= 1'b0;
            overflow_q   <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        snapshot_q <= taps;
                        busy_q     <= 1'b1;
                        state_q    <= FILTER;
                    end
                end
                FILTER: begin
                    corrected_q <= corrected_d;
                    state_q     <= ENCODE;
                end
                ENCODE: begin
                    result_q     <= count_d;
                    edge_found_q <= (count_d != '0);
                    overflow_q   <= (count_d == CNT_W'(N_TAPS));
                    valid_q      <= 1'b1;
                    state_q      <= OUTPUT;
                end
                OUTPUT: begin
                    if (res_if.ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= arm ? ARMED : IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res_if.result     = result_q;
    assign res_if.edge_found = edge_found_q;
    assign res_if.overflow   = overflow_q;
    assign res_if.valid      = valid_q;
    assign busy              = busy_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_delay_tap_encoder.sv
// Directed and randomized checks of delay_tap_encoder against a bubble-vote /
// leading-ones reference computed directly from the tap vector.
module tb_delay_tap_encoder;

    localparam int N = 64;
    localparam int W = 7;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] taps;
    logic         arm;
    logic         trigger;
    logic         busy;
    logic [2:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    delay_tap_encoder_if #(.CNT_W(W)) res_if ();

    delay_tap_encoder #(.N_TAPS(N), .CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .taps      (taps),
        .arm       (arm),
        .trigger   (trigger),
        .busy      (busy),
        .state_dbg (state_dbg),
        .res_if    (res_if.master)
    );

    always #5 clk = ~clk;

    function automatic int ref_count(input logic [N-1:0] t);
        bit c[N];
        int n;
        for (int i = 0; i < N; i++) begin
            int votes;
            votes = int'(t[(i == 0) ? 0 : i - 1]) + int'(t[i]) +
                    int'(t[(i == N - 1) ? N - 1 : i + 1]);
            c[i] = (votes >= 2);
        end
        n = 0;
        while (n < N && c[n]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] t);
        int e;
        e = ref_count(t);
        check({tag, ".valid"}, 64'(res_if.valid), 64'(1));
        check({tag, ".result"}, 64'(res_if.result), 64'(e));
        check({tag, ".edge"}, 64'(res_if.edge_found), 64'(e > 0));
        check({tag, ".ovf"}, 64'(res_if.overflow), 64'(e == N));
    endtask

    // From ARMED: trigger at edge T, expect valid after T+2, transfer at T+3.
    task automatic run_capture(input string tag, input logic [N-1:0] t, input logic rearm);
        taps          = t;
        trigger       = 1'b1;
        res_if.ready  = 1'b1;
        tick();
        trigger = 1'b0;
        taps    = {$urandom, $urandom};
        check({tag, ".busy_T"}, 64'(busy), 64'(1));
        check({tag, ".valid_T"}, 64'(res_if.valid), 64'(0));
        tick();
        check({tag, ".valid_T1"}, 64'(res_if.valid), 64'(0));
        tick();
        check_result(tag, t);
        check({tag, ".state_T2"}, 64'(state_dbg), 64'(S_OUTPUT));
        arm = rearm;
        tick();
        arm = 1'b0;
        res_if.ready = 1'b0;
        check({tag, ".valid_T3"}, 64'(res_if.valid), 64'(0));
        check({tag, ".busy_T3"}, 64'(busy), 64'(0));
        check({tag, ".state_T3"}, 64'(state_dbg), 64'(rearm ? S_ARMED : S_IDLE));
    endtask

    task automatic arm_up();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed", 64'(state_dbg), 64'(S_ARMED));
    endtask

    initial begin
        logic [N-1:0] t;
        logic [W-1:0] held;
        rst = 1'b1; arm = 1'b0; trigger = 1'b0; taps = '0; res_if.ready = 1'b0;

        // Reset, then a trigger without arm must be ignored.
        repeat (3) tick();
        check("rst.valid", 64'(res_if.valid), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.result", 64'(res_if.result), 64'(0));
        check("rst.edge", 64'(res_if.edge_found), 64'(0));
        check("rst.ovf", 64'(res_if.overflow), 64'(0));
        check("rst.state", 64'(state_dbg), 64'(S_IDLE));
        rst = 1'b0;
        taps = '1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (3) tick();
        check("notrig.state", 64'(state_dbg), 64'(S_IDLE));
        check("notrig.valid", 64'(res_if.valid), 64'(0));
        check("notrig.busy", 64'(busy), 64'(0));

        // Directed patterns, with explicit expected counts as well.
        arm_up(); run_capture("clean", 64'h0000_0000_0000_FFFF, 1'b0);
        check("clean.count", 64'(ref_count(64'h0000_0000_0000_FFFF)), 64'd16);
        arm_up(); run_capture("bubble", 64'h0000_0000_000F_FF7F, 1'b0);
        check("bubble.count", 64'(ref_count(64'h0000_0000_000F_FF7F)), 64'd20);
        arm_up(); run_capture("pad0", 64'h0000_0000_0000_00FE, 1'b0);
        arm_up(); run_capture("ones", {N{1'b1}}, 1'b0);
        check("ones.ovf_abs", 64'(res_if.overflow), 64'(1));
        check("ones.result_abs", 64'(res_if.result), 64'd64);
        arm_up(); run_capture("zeros", {N{1'b0}}, 1'b0);

        // Backpressure: outputs frozen, triggers ignored, then re-arm on transfer.
        arm_up();
        t = 64'h0000_0FFF_FFFF_FFFF;
        taps = t; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (2) tick();
        check_result("bp", t);
        held = W'(ref_count(t));
        for (int k = 0; k < 10; k++) begin
            trigger = 1'($urandom_range(0, 1));
            taps    = {$urandom, $urandom};
            tick();
            check("bp.valid", 64'(res_if.valid), 64'(1));
            check("bp.result", 64'(res_if.result), 64'(held));
            check("bp.state", 64'(state_dbg), 64'(S_OUTPUT));
        end
        trigger = 1'b0;
        res_if.ready = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0; res_if.ready = 1'b0;
        check("rearm.valid", 64'(res_if.valid), 64'(0));
        check("rearm.state", 64'(state_dbg), 64'(S_ARMED));
        run_capture("rearm2", 64'h0000_0000_0000_0003, 1'b0);

        // Reset while in FILTER discards the capture.
        arm_up();
        taps = 64'h0000_0000_0000_00FF; trigger = 1'b1;
        tick();
        trigger = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.state", 64'(state_dbg), 64'(S_IDLE));
        check("midrst.busy", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst.valid", 64'(res_if.valid), 64'(0));
        end
        arm_up(); run_capture("postrst", 64'h0000_0000_00FF_FFFF, 1'b0);

        // Randomized thermometer codes with sparse bubbles, plus raw random vectors.
        for (int k = 0; k < 24; k++) begin
            int len;
            len = $urandom_range(0, N);
            t = (len == N) ? {N{1'b1}} : ((64'd1 << len) - 64'd1);
            if (k % 4 == 3) begin
                t = {$urandom, $urandom};
            end else begin
                for (int b = 0; b < 2; b++) t[$urandom_range(0, N - 1)] ^= 1'b1;
            end
            if (k % 3 == 0) begin
                arm_up(); run_capture("rand", t, 1'b0);
            end else begin
                arm_up(); run_capture("rand_rearm", t, 1'b1);
                tick();
                rst = 1'b1; tick(); rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_tap_encoder.md
Name: delay_tap_encoder

Overview:
Downstream consumer of the single-flip-flop delay-line chain. It takes the parallel tap vector produced by N cascaded delay stages and snapshots it on a trigger. It then bubble-corrects the thermometer code and encodes it into a binary tap count, which it hands off over a valid/ready interface. Runs on the 100 MHz system clock.

Parameters:
- N_TAPS, 64, number of delay-line taps presented on `taps`.
- CNT_W, 7, width of `result`; must satisfy 2^CNT_W > N_TAPS (holds N_TAPS itself).

Ports:
- clk  in  1  system clock, 100 MHz, rising edge used.
- rst  in  1  synchronous, active-high reset.
- taps  in  N_TAPS  delay-line outputs; tap 0 is nearest the line input. Updated on falling edge upstream, so it is stable at the rising edge.
- arm  in  1  request to arm for one capture.
- trigger  in  1  capture strobe; honoured only in ARMED.
- result  out  CNT_W  corrected count of leading ones, from tap 0 upward.
- edge_found  out  1  result > 0.
- overflow  out  1  all corrected taps are 1 (result == N_TAPS).
- valid  out  1  result/flags valid.
- ready  in  1  consumer accepts result when valid && ready at a rising edge.
- busy  out  1  high in FILTER, ENCODE, OUTPUT.

Behaviour:
- One clock (clk); reset is synchronous, active-high, on rst. All state updates on rising edge of clk.
- Reset values: result=0, edge_found=0, overflow=0, valid=0, busy=0, FSM=IDLE, snapshot/corrected registers=0.
- FSM states: IDLE, ARMED, FILTER, ENCODE, OUTPUT.
  - IDLE: arm=1 -> ARMED.
  - ARMED: trigger=1 -> FILTER; the same edge registers snapshot <= taps. Otherwise stay. arm is a don't-care here.
  - FILTER: bubble correction registered into `corrected`; unconditional -> ENCODE.
  - ENCODE: result, edge_found and overflow registered; valid <= 1; unconditional -> OUTPUT.
  - OUTPUT: hold all outputs stable while ready=0.
    - ready=1 -> valid <= 0.
    - Next state is ARMED if arm=1 on that same edge, else IDLE.
- Bubble correction, for each tap i: corrected[i] = majority(s[i-1], s[i], s[i+1]).
  - Edge padding: s[-1]=s[0], s[N_TAPS]=s[N_TAPS-1].
- Encoding: result = count of consecutive 1s in `corrected` starting at index 0, stopping at the first 0. Later 1s are ignored.
  - All ones: result=N_TAPS, overflow=1.
  - corrected[0]=0: result=0, edge_found=0.
- Latency:
  - Trigger sampled at edge T.
  - valid rises at edge T+2 (first visible in the cycle after T+2).
  - The earliest transfer edge is T+3.
- Ignored inputs:
  - trigger outside ARMED is ignored (no queuing).
  - arm outside IDLE/OUTPUT-exit is ignored.
- rst mid-operation (any state): returns to IDLE next edge. In-flight snapshot is discarded, valid drops, no result is emitted.
- ready while valid=0 has no effect.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: rst=1 for 3 cycles, then trigger pulsed without arm -> valid, busy, result and flags all stay 0; FSM remains IDLE.
2. Clean code: arm, taps=64'h0000_0000_0000_FFFF, trigger at edge T, ready=1 -> valid=1 after T+2, result=16, edge_found=1, overflow=0; valid drops after T+3.
3. Bubble: taps=64'h0000_0000_000F_FF7F (bit 7 zero), then trigger -> result=20. Separately, taps=64'h0000_0000_0000_00FE -> tap 0 padded to 0, result=0, edge_found=0.
4. Extremes:
   - taps all ones -> result=64, overflow=1, edge_found=1.
   - taps all zeros -> result=0, edge_found=0, overflow=0.
5. Backpressure and re-arm:
   - Hold ready=0 for 10 cycles after valid -> result and flags stable, valid stays 1, extra trigger pulses ignored.
   - ready=1 with arm=1 -> valid=0 next edge, FSM=ARMED.
   - A new trigger with taps=64'h0000_0000_0000_0003 then yields result=2.
6. Reset mid-capture: assert rst for one cycle in FILTER -> valid never asserts for that capture, busy=0, FSM=IDLE; next arm/trigger works normally.
